// File: rtl/hazard3_ahb_arbiter_2to1.sv
// hazard3_ahb_arbiter_2to1: fixed-priority I/D to single AHB-Lite master arbiter with grant hold.
// Optional I-side starvation guard enabled by defining HAZARD3_ARB_STARVE_GUARD_EN.
module hazard3_ahb_arbiter_2to1 #(
  parameter int W_ADDR       = 32,
  parameter int W_DATA       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              aph_req_i,
  input  logic              aph_panic_i,
  output logic              aph_ready_i,
  output logic              dph_ready_i,
  output logic              dph_err_i,
  input  logic [W_ADDR-1:0] haddr_i,
  input  logic [2:0]        hsize_i,
  output logic [W_DATA-1:0] rdata_i,
  input  logic              aph_req_d,
  output logic              aph_ready_d,
  output logic              dph_ready_d,
  output logic              dph_err_d,
  input  logic [W_ADDR-1:0] haddr_d,
  input  logic [2:0]        hsize_d,
  input  logic              hwrite_d,
  input  logic [W_DATA-1:0] wdata_d,
  output logic [W_DATA-1:0] rdata_d,
  output logic [W_ADDR-1:0] haddr,
  output logic              hwrite,
  output logic [1:0]        htrans,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [3:0]        hprot,
  output logic              hmastlock,
  input  logic              hready,
  input  logic              hresp,
  output logic [W_DATA-1:0] hwdata,
  input  logic [W_DATA-1:0] hrdata
);
  logic hold_valid, hold_d, dph_own_i, dph_own_d;
  logic force_i, raw_gnt_i, raw_gnt_d, gnt_i, gnt_d, gnt_any;
`ifdef HAZARD3_ARB_STARVE_GUARD_EN
  localparam int W_CNT = $clog2(STARVE_LIMIT + 1);
  logic [W_CNT-1:0] starve_cnt;
  assign force_i = aph_req_i && starve_cnt == W_CNT'(STARVE_LIMIT);
  // Counts accepted-slot cycles in which I waited; saturates at the limit.
  always_ff @(posedge clk or posedge rst)
    if (rst)
      starve_cnt <= '0;
    else if (!aph_req_i || (hready && gnt_i))
      starve_cnt <= '0;
    else if (hready && starve_cnt != W_CNT'(STARVE_LIMIT))
      starve_cnt <= starve_cnt + 1'b1;
`else
  assign force_i = 1'b0 && STARVE_LIMIT != 0;
`endif
  assign raw_gnt_d = aph_req_d && !(aph_req_i && aph_panic_i) && !force_i;
  assign raw_gnt_i = aph_req_i && !raw_gnt_d;
  // A stalled address phase keeps its owner; if that owner withdraws, the bus goes IDLE.
  assign gnt_d   = hold_valid ? hold_d && aph_req_d : raw_gnt_d;
  assign gnt_i   = hold_valid ? !hold_d && aph_req_i : raw_gnt_i;
  assign gnt_any = gnt_i || gnt_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hold_valid <= 1'b0;
      hold_d     <= 1'b0;
      dph_own_i  <= 1'b0;
      dph_own_d  <= 1'b0;
    end else begin
      hold_valid <= !hready && gnt_any;
      if (!hready && gnt_any)
        hold_d <= gnt_d;
      if (hready) begin
        dph_own_i <= gnt_i;
        dph_own_d <= gnt_d;
      end
    end
  assign htrans      = gnt_any ? 2'b10 : 2'b00;
  assign haddr       = gnt_i ? haddr_i : haddr_d;
  assign hsize       = gnt_i ? hsize_i : hsize_d;
  assign hprot       = gnt_i ? 4'b0010 : 4'b0011;
  assign hwrite      = hwrite_d && gnt_d;
  assign hburst      = 3'b000;
  assign hmastlock   = 1'b0;
  assign hwdata      = wdata_d;
  assign aph_ready_i = hready && gnt_i;
  assign aph_ready_d = hready && gnt_d;
  assign dph_ready_i = hready && dph_own_i;
  assign dph_ready_d = hready && dph_own_d;
  assign dph_err_i   = hready && dph_own_i && hresp;
  assign dph_err_d   = dph_own_d && hresp;
  assign rdata_i     = hrdata;
  assign rdata_d     = hrdata;
endmodule
